// File: rtl/pipe_stage_reg.sv
// Purpose : elastic pipeline register between pipeline stages, optional two-entry skid, flush-to-bubble, stall counter.
// Latency : one cycle; data accepted at edge N is on out_data with out_valid=1 after edge N.
// Backpressure: SKID=1 holds up to two entries with registered in_ready; SKID=0 holds one with in_ready = !out_valid | out_ready.
module pipe_stage_reg #(
    parameter int               WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam bit HAS_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_in_rdy;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_accept;
    logic             w_deliver;
    logic             w_in_rdy_comb;

    assign out_valid     = (r_state != ST_EMPTY);
    assign out_data      = r_main;
    assign stall_cnt     = r_stall_cnt;
    // Single-entry variant lets a downstream take make room in the same cycle.
    assign w_in_rdy_comb = !out_valid || out_ready;
    assign in_ready      = HAS_SKID ? r_in_rdy : w_in_rdy_comb;
    assign w_accept      = in_valid && in_ready;
    assign w_deliver     = out_valid && out_ready;

    // Next-state and datapath selection; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_main_nxt  = in_data;
                end
            end
            ST_FULL: begin
                if (w_accept && w_deliver) begin
                    w_main_nxt = in_data;
                end else if (w_accept) begin
                    // Only the skid variant can accept while the main entry is stuck.
                    if (HAS_SKID) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data;
                    end
                end else if (w_deliver) begin
                    // Main keeps its stale value; out_valid=0 marks it as empty.
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_deliver) begin
                    w_state_nxt = ST_FULL;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_main_nxt  = BUBBLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
        end
    end

    // State, payload and registered ready; ready is computed from the next state so it has no out_ready path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_main   <= BUBBLE;
            r_skid   <= BUBBLE;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_main   <= w_main_nxt;
            r_skid   <= w_skid_nxt;
            r_in_rdy <= (w_state_nxt != ST_SKID);
        end
    end

    // Saturating count of cycles where downstream refuses valid data; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose : checks pipe_stage_reg (SKID=1/CNT_W=3 and SKID=0/CNT_W=16) against a queue-based occupancy model.
// Latency : model expects data on out_data the cycle after acceptance.
// Backpressure: model allows two held entries for the skid variant, one for the single-entry variant.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        iv[2];
    logic        ordy[2];
    logic        fl[2];
    logic        sclr[2];
    logic [31:0] idat[2];
    logic        ir[2];
    logic        ov[2];
    logic [31:0] od[2];
    logic [2:0]  sc0;
    logic [15:0] sc1;

    int          n_chk;
    int          n_fail;
    int          n_deliv;
    int          cnt;
    logic [31:0] last_out;
    logic [31:0] q[$];

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .BUBBLE(BUB), .CNT_W(3)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .flush(fl[0]), .stall_cnt(sc0), .stall_clr(sclr[0])
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .BUBBLE(BUB), .CNT_W(16)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .flush(fl[1]), .stall_cnt(sc1), .stall_clr(sclr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_sc(input int d);
        return (d == 0) ? {29'd0, sc0} : {16'd0, sc1};
    endfunction

    function automatic int cmax(input int d);
        return (d == 0) ? 7 : 65535;
    endfunction

    task automatic model_reset();
        q.delete();
        cnt      = 0;
        last_out = BUB;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
            fl[i]   = 1'b0;
            sclr[i] = 1'b0;
            idat[i] = 32'd0;
        end
    endtask

    // One clock cycle on DUT d: compare outputs with the model, then advance the model.
    task automatic tick(input int d);
        bit exp_ir;
        bit acc;
        bit dlv;
        #1;
        exp_ir = (d == 0) ? (q.size() < 2) : (q.size() == 0 || ordy[d]);
        chk("out_valid", {31'd0, ov[d]}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, ir[d]}, {31'd0, exp_ir});
        chk("out_data", od[d], (q.size() > 0) ? q[0] : last_out);
        chk("stall_cnt", get_sc(d), cnt);
        acc = iv[d] && exp_ir;
        dlv = (q.size() > 0) && ordy[d];
        if (sclr[d]) cnt = 0;
        else if (q.size() > 0 && !ordy[d] && cnt < cmax(d)) cnt++;
        if (fl[d]) begin
            if (dlv) n_deliv++;
            q.delete();
            last_out = BUB;
        end else begin
            if (dlv) begin
                last_out = q.pop_front();
                n_deliv++;
            end
            if (acc) q.push_back(idat[d]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #3 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic stream(input int d);
        int start;
        start = n_deliv;
        for (int k = 1; k <= 64; k++) begin
            iv[d]   = 1'b1;
            idat[d] = k;
            ordy[d] = 1'b1;
            tick(d);
        end
        iv[d] = 1'b0;
        tick(d);
        chk("stream_count", n_deliv - start, 64);
    endtask

    task automatic random_run(input int d, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            iv[d]   = ($urandom_range(0, 9) < 7);
            ordy[d] = ($urandom_range(0, 9) < 6);
            fl[d]   = ($urandom_range(0, 99) < 3);
            sclr[d] = ($urandom_range(0, 99) < 1);
            idat[d] = $urandom;
            tick(d);
        end
        idle_inputs();
        tick(d);
        tick(d);
    endtask

    initial begin
        int start;
        n_chk   = 0;
        n_fail  = 0;
        n_deliv = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", {31'd0, ov[d]}, 32'd0);
            chk("rst_out_data", od[d], BUB);
            chk("rst_in_ready", {31'd0, ir[d]}, 32'd1);
            chk("rst_stall_cnt", get_sc(d), 32'd0);
        end
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-entry variant: streaming, then reset while holding data.
        stream(1);
        iv[1] = 1'b1; idat[1] = 32'hAAAA_0001; ordy[1] = 1'b0;
        tick(1);
        tick(1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, ov[1]}, 32'd0);
        chk("midrst_out_data", od[1], BUB);
        chk("midrst_in_ready", {31'd0, ir[1]}, 32'd1);
        chk("midrst_stall_cnt", get_sc(1), 32'd0);
        idle_inputs();
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Skid variant: streaming.
        stream(0);

        // Backpressure into the skid entry.
        sclr[0] = 1'b1; tick(0); sclr[0] = 1'b0;
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 32'hA;
        tick(0);
        idat[0] = 32'hB;
        tick(0);
        iv[0] = 1'b0;
        repeat (4) tick(0);
        chk("bp_stall_cnt", get_sc(0), 32'd5);
        chk("bp_in_ready", {31'd0, ir[0]}, 32'd0);
        chk("bp_head", od[0], 32'hA);
        ordy[0] = 1'b1;
        tick(0);
        chk("bp_second", od[0], 32'hB);
        chk("bp_second_valid", {31'd0, ov[0]}, 32'd1);
        tick(0);
        chk("bp_drained", {31'd0, ov[0]}, 32'd0);

        // Flush while in the skid state with a new input offered.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 32'hC1; tick(0);
        idat[0] = 32'hC2; tick(0);
        start = n_deliv;
        fl[0] = 1'b1; idat[0] = 32'hC3; tick(0);
        fl[0] = 1'b0; iv[0] = 1'b0;
        chk("flush_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("flush_out_data", od[0], BUB);
        chk("flush_in_ready", {31'd0, ir[0]}, 32'd1);
        ordy[0] = 1'b1;
        repeat (3) tick(0);
        chk("flush_no_deliver", n_deliv - start, 32'd0);

        // Counter saturation and clear priority.
        sclr[0] = 1'b1; tick(0); sclr[0] = 1'b0;
        chk("clr_stall_cnt", get_sc(0), 32'd0);
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 32'hD; tick(0);
        iv[0] = 1'b0;
        repeat (10) tick(0);
        chk("sat_stall_cnt", get_sc(0), 32'd7);
        sclr[0] = 1'b1; tick(0); sclr[0] = 1'b0;
        chk("clr_in_stall", get_sc(0), 32'd0);
        ordy[0] = 1'b1;
        tick(0);

        // Random traffic on both variants.
        random_run(0, 10000);
        do_reset();
        random_run(1, 10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register with a valid/ready handshake, an optional skid buffer, a synchronous flush that inserts a bubble, and a saturating stall counter. It generalises the plain write-enabled pipeline register used between IF/ID/EX/MEM/WB. Stages can stall locally without a global write-enable net, and branch/exception flushes can be applied per stage. One instance sits on each inter-stage boundary of the RISC-V pipeline.

## Interface
- WIDTH, 32: payload width in bits (>=1).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE, '0: WIDTH-bit value loaded into the main register on reset and flush (e.g. NOP encoding).
- CNT_W, 16: stall counter width (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload; driven directly from the main register.
- flush  in  1  synchronous kill of all held and incoming entries.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Handshakes: accept = in_valid & in_ready; deliver = out_valid & out_ready. Data is never dropped or duplicated unless flush is asserted.
- States: EMPTY (no entry), FULL (main only), SKID (main + skid; reachable only with SKID=1).
- EMPTY: if accept, move to FULL with main <= in_data.
- FULL with accept & deliver: stay FULL, main <= in_data.
- FULL with accept & !deliver: SKID=1 moves to SKID with skid <= in_data. SKID=0 cannot reach this case, because in_ready=0 then.
- FULL with !accept & deliver: move to EMPTY; main holds its last value.
- FULL with neither: hold.
- SKID: in_ready=0. On deliver, move to FULL with main <= skid. Otherwise hold.
- in_ready, SKID=1: registered, equals (next state != SKID). It is 1 in EMPTY and FULL and 0 in SKID.
- in_ready, SKID=0: combinational, equals !out_valid | out_ready.
- out_valid = (state != EMPTY).
- flush has the highest priority. Next state is EMPTY and main <= BUBBLE. The skid entry and any entry accepted in the flush cycle are discarded. A deliver in the flush cycle still counts as completed downstream.
- stall_cnt: increments on each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1 (no wrap). stall_clr sets it to 0 and wins over an increment in the same cycle. flush does not affect it.

## Timing
- Reset (rst_n=0, asynchronous, immediate):
  - state EMPTY, out_valid=0, out_data=BUBBLE, stall_cnt=0.
  - in_ready=1 after reset for both SKID values.
- Reset mid-operation: all held entries are lost, with no partial update; the stage is usable on the first clk edge after rst_n rises.
- Latency: in_data accepted at edge N appears on out_data with out_valid=1 after edge N; a same-cycle deliver can occur in cycle N+1.
- Throughput: one transfer per cycle under continuous in_valid and out_ready, for both SKID values.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has one.
- Flush asserted at edge N: out_valid=0 and out_data=BUBBLE after edge N; in_ready=1 after edge N.

## Test plan
- Reset with BUBBLE=32'h00000013:
  - out_valid=0, out_data=32'h13, in_ready=1, stall_cnt=0.
  - Assert rst_n=0 mid-transfer: all of these return immediately without waiting for clk.
- Streaming, SKID=1 and SKID=0: feed 0x1..0x40 with out_ready=1 on every cycle → outputs in order, one per cycle, after the first-cycle latency.
- Backpressure, SKID=1: send A then B, hold out_ready=0 for 5 cycles.
  - State is SKID and in_ready=0; stall_cnt=5.
  - Release out_ready → A then B delivered on consecutive cycles, no loss.
- Flush in SKID state with in_valid=1 → next cycle out_valid=0, out_data=BUBBLE, in_ready=1; neither held entry nor the input is ever delivered.
- Counter limits, CNT_W=3: stall 10 cycles → stall_cnt=7. Assert stall_clr in a stall cycle → stall_cnt=0.
- Random valid/ready with a scoreboard, 10k cycles, both SKID values → exact in-order match, never out_valid=1 with X data.
